// File: rtl/maze_game_core.sv
// maze_game_core: player position, direction choice, wall collision, visited/score
// tracking, elapsed-seconds timer and end-of-game detection for an arbitrary grid.
// Optional macro MAZE_TIME_PENALTY_EN: final_score = score - seconds (floored at 0);
// otherwise final_score follows score.
module maze_game_core #(
  parameter int unsigned COLS         = 10,
  parameter int unsigned ROWS         = 15,
  parameter int unsigned CELL_BITS    = 5,
  parameter int unsigned SPEED_FACTOR = 32,
  parameter int unsigned FREQUENCY    = 50000000,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned START_SCORE  = 150,
  parameter int unsigned FOOD_COST_0  = 1,
  parameter int unsigned FOOD_COST_1  = 4,
  parameter int unsigned FOOD_COST_2  = 16,
  parameter int unsigned FOOD_COST_3  = 64,
  localparam int unsigned XW          = $clog2(COLS) + CELL_BITS,
  localparam int unsigned YW          = $clog2(ROWS) + CELL_BITS,
  localparam int unsigned CELLS       = COLS * ROWS,
  localparam int unsigned HW          = (ROWS + 1) * COLS,
  localparam int unsigned VW          = ROWS * (COLS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [3:0]           btn,
  input  logic [HW-1:0]        h_walls,
  input  logic [VW-1:0]        v_walls,
  input  logic [2*CELLS-1:0]   food,
  output logic [XW-1:0]        pos_x,
  output logic [YW-1:0]        pos_y,
  output logic [1:0]           direction,
  output logic [CELLS-1:0]     visited,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   seconds,
  output logic [SCORE_W-1:0]   final_score,
  output logic                 game_over
);

  localparam int unsigned HIDX_W = $clog2(HW);
  localparam int unsigned VIDX_W = $clog2(VW);
  localparam int unsigned CIDX_W = $clog2(CELLS);
  localparam int unsigned FIDX_W = $clog2(2 * CELLS);
  localparam int unsigned CNT_W  = $clog2(SPEED_FACTOR);
  localparam int unsigned SUB_W  = (FREQUENCY > 1) ? $clog2(FREQUENCY) : 1;
  localparam int unsigned SW1    = SCORE_W + 1;

  typedef enum logic [1:0] {
    S_DECIDE = 2'd0,
    S_MOVE   = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [SUB_W-1:0]   sub, sub_d;
  logic               path_free, path_free_d;
  logic [XW-1:0]      pos_x_d, px_step;
  logic [YW-1:0]      pos_y_d, py_step;
  logic [1:0]         direction_d, dir_new;
  logic [CELLS-1:0]   visited_d;
  logic [SCORE_W-1:0] score_d, seconds_d, final_d, score_sat;
  logic               game_over_d;

  int unsigned        cx, cy, cost;
  logic [VIDX_W-1:0]  idx_right, idx_left;
  logic [HIDX_W-1:0]  idx_down, idx_up;
  logic [CIDX_W-1:0]  idx_cell;
  logic [FIDX_W-1:0]  idx_food_lo, idx_food_hi;
  logic [3:0]         free;
  logic [1:0]         food_code;
  logic [SW1-1:0]     score_sum;
  logic               aligned_next;

  // Cell lookup: free directions, food code and saturated score for the current cell
  always_comb begin
    cx          = 32'(pos_x[XW-1:CELL_BITS]);
    cy          = 32'(pos_y[YW-1:CELL_BITS]);
    idx_right   = VIDX_W'(cy * (COLS + 1) + cx + 1);
    idx_left    = VIDX_W'(cy * (COLS + 1) + cx);
    idx_down    = HIDX_W'((cy + 1) * COLS + cx);
    idx_up      = HIDX_W'(cy * COLS + cx);
    idx_cell    = CIDX_W'(cy * COLS + cx);
    idx_food_lo = FIDX_W'(2 * (cy * COLS + cx));
    idx_food_hi = FIDX_W'(2 * (cy * COLS + cx) + 1);
    free[0]     = !v_walls[idx_right] && (cx < COLS - 1);
    free[1]     = !h_walls[idx_down]  && (cy < ROWS - 1);
    free[2]     = !v_walls[idx_left]  && (cx > 0);
    free[3]     = !h_walls[idx_up]    && (cy > 0);
    food_code   = {food[idx_food_hi], food[idx_food_lo]};
    case (food_code)
      2'd0:    cost = FOOD_COST_0;
      2'd1:    cost = FOOD_COST_1;
      2'd2:    cost = FOOD_COST_2;
      default: cost = FOOD_COST_3;
    endcase
    score_sum = {1'b0, score} + SW1'(cost);
    score_sat = score_sum[SW1-1] ? '1 : score_sum[SCORE_W-1:0];
  end

  // Direction choice (right > down > left > up among free, requested ones) and step target
  always_comb begin
    dir_new = direction;
    if (btn[0] && free[0])      dir_new = 2'd0;
    else if (btn[1] && free[1]) dir_new = 2'd1;
    else if (btn[2] && free[2]) dir_new = 2'd2;
    else if (btn[3] && free[3]) dir_new = 2'd3;
    px_step = pos_x;
    py_step = pos_y;
    if (path_free) begin
      case (direction)
        2'd0:    px_step = pos_x + XW'(1);
        2'd1:    py_step = pos_y + YW'(1);
        2'd2:    px_step = pos_x - XW'(1);
        default: py_step = pos_y - YW'(1);
      endcase
    end
    aligned_next = (px_step[CELL_BITS-1:0] == '0) && (py_step[CELL_BITS-1:0] == '0);
  end

  // Next-state logic for the movement FSM, timer and score display
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    path_free_d = path_free;
    pos_x_d     = pos_x;
    pos_y_d     = pos_y;
    direction_d = direction;
    visited_d   = visited;
    score_d     = score;
    sub_d       = sub;
    seconds_d   = seconds;
    game_over_d = game_over | (&visited);

    case (state)
      S_DECIDE: begin
        if (run) begin
          direction_d = dir_new;
          path_free_d = free[dir_new];
          if (!visited[idx_cell]) begin
            visited_d = visited | (CELLS'(1) << idx_cell);
            score_d   = score_sat;
          end
          cnt_d   = CNT_W'(SPEED_FACTOR - 1);
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (run) begin
          if (cnt == '0) begin
            cnt_d   = CNT_W'(SPEED_FACTOR - 1);
            pos_x_d = px_step;
            pos_y_d = py_step;
            if (!path_free || aligned_next) state_d = S_DECIDE;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
      end
      S_DONE: ;
      default: state_d = S_DECIDE;
    endcase

    // Every cell scored: park the FSM until reset
    if (&visited) state_d = S_DONE;

    if (!game_over) begin
      if (sub == '0) begin
        sub_d = SUB_W'(FREQUENCY - 1);
        if (seconds != '1) seconds_d = seconds + SCORE_W'(1);
      end else begin
        sub_d = sub - SUB_W'(1);
      end
    end

`ifdef MAZE_TIME_PENALTY_EN
    final_d = (seconds > score) ? '0 : score - seconds;
`else
    final_d = score;
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_DECIDE;
      cnt         <= CNT_W'(SPEED_FACTOR - 1);
      path_free   <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      direction   <= 2'd2;
      visited     <= '0;
      score       <= SCORE_W'(START_SCORE);
      sub         <= SUB_W'(FREQUENCY - 1);
      seconds     <= '0;
      final_score <= '0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      path_free   <= path_free_d;
      pos_x       <= pos_x_d;
      pos_y       <= pos_y_d;
      direction   <= direction_d;
      visited     <= visited_d;
      score       <= score_d;
      sub         <= sub_d;
      seconds     <= seconds_d;
      final_score <= final_d;
      game_over   <= game_over_d;
    end
  end

endmodule

// File: tb/tb_maze_game_core.sv
// Directed bench for maze_game_core on a 2x2 grid, CELL_BITS=1, SPEED_FACTOR=2, FREQUENCY=4.
module tb_maze_game_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  btn = 4'd0;
  logic [5:0]  h_walls = 6'd0;
  logic [5:0]  v_walls = 6'd0;
  logic [7:0]  food = 8'd0;
  logic [1:0]  pos_x, pos_y, direction;
  logic [3:0]  visited;
  logic [15:0] score, seconds, final_score;
  logic        game_over;

  int errors = 0;
  int checks = 0;

  maze_game_core #(
    .COLS(2), .ROWS(2), .CELL_BITS(1), .SPEED_FACTOR(2), .FREQUENCY(4),
    .SCORE_W(16), .START_SCORE(150),
    .FOOD_COST_0(1), .FOOD_COST_1(4), .FOOD_COST_2(16), .FOOD_COST_3(64)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .btn(btn),
    .h_walls(h_walls), .v_walls(v_walls), .food(food),
    .pos_x(pos_x), .pos_y(pos_y), .direction(direction), .visited(visited),
    .score(score), .seconds(seconds), .final_score(final_score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos_x"}, 32'(pos_x), 0);
    check({tag, "_pos_y"}, 32'(pos_y), 0);
    check({tag, "_dir"}, 32'(direction), 2);
    check({tag, "_visited"}, 32'(visited), 0);
    check({tag, "_score"}, 32'(score), 150);
    check({tag, "_seconds"}, 32'(seconds), 0);
    check({tag, "_final"}, 32'(final_score), 0);
    check({tag, "_game_over"}, 32'(game_over), 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_reset_values("rst");

    // Open grid, no buttons: cell 0 scored, direction stays left, blocked by edge
    run = 1'b1;
    tick(1);
    check("idle_score", 32'(score), 151);
    check("idle_visited", 32'(visited), 1);
    check("idle_dir", 32'(direction), 2);
    tick(1);
    check("idle_final", 32'(final_score), 151);
    tick(8);
    check("idle_pos_x", 32'(pos_x), 0);
    check("idle_pos_y", 32'(pos_y), 0);
    check("idle_score_hold", 32'(score), 151);

    // Right held: half-cell after 2 MOVE cycles, next cell after 4, then scored
    do_reset();
    btn = 4'b0001;
    run = 1'b1;
    tick(1);
    check("right_dir", 32'(direction), 0);
    tick(2);
    check("right_half", 32'(pos_x), 1);
    tick(2);
    check("right_full", 32'(pos_x), 2);
    check("right_score_pre", 32'(score), 151);
    tick(1);
    check("right_score", 32'(score), 152);
    check("right_visited", 32'(visited), 3);
    check("right_dir_keep", 32'(direction), 0);

    // Wall right of cell 0 with right|down: down wins
    do_reset();
    v_walls = 6'b000010;
    btn = 4'b0011;
    run = 1'b1;
    tick(1);
    check("wall_dir", 32'(direction), 1);
    tick(2);
    check("wall_pos_y_half", 32'(pos_y), 1);
    tick(2);
    check("wall_pos_y", 32'(pos_y), 2);
    check("wall_pos_x", 32'(pos_x), 0);
    tick(1);
    check("wall_visited", 32'(visited), 5);
    check("wall_score", 32'(score), 152);
    v_walls = 6'd0;

    // Food code 3 everywhere, visit all four cells: right, down, left
    do_reset();
    food = 8'hFF;
    btn = 4'b0001;
    run = 1'b1;
    tick(1);
    check("food_c0", 32'(score), 214);
    tick(4);
    btn = 4'b0010;
    tick(1);
    check("food_c1", 32'(score), 278);
    check("food_dir_down", 32'(direction), 1);
    tick(4);
    btn = 4'b0100;
    tick(1);
    check("food_c3", 32'(score), 342);
    check("food_vis3", 32'(visited), 11);
    tick(4);
    check("food_pos_x_back", 32'(pos_x), 0);
    tick(1);
    check("food_c2", 32'(score), 406);
    check("food_vis_all", 32'(visited), 15);
    check("food_go_pre", 32'(game_over), 0);
    tick(1);
    check("food_game_over", 32'(game_over), 1);
    check("food_seconds", 32'(seconds), 4);
    btn = 4'b0001;
    tick(20);
    check("done_seconds_frozen", 32'(seconds), 4);
    check("done_dir", 32'(direction), 2);
    check("done_pos_x", 32'(pos_x), 0);
    check("done_pos_y", 32'(pos_y), 2);
    check("done_score", 32'(score), 406);
    check("done_final", 32'(final_score), 406);
    check("done_game_over", 32'(game_over), 1);
    food = 8'd0;
    btn = 4'd0;

    // Timer: four clocks per second, counting from reset release
    do_reset();
    run = 1'b1;
    tick(400);
    check("timer_400", 32'(seconds), 100);
`ifdef MAZE_TIME_PENALTY_EN
    check("final_400", 32'(final_score), 52);
`else
    check("final_400", 32'(final_score), 151);
`endif
    tick(208);
    check("timer_608", 32'(seconds), 152);
    check("timer_score", 32'(score), 151);
`ifdef MAZE_TIME_PENALTY_EN
    check("final_608", 32'(final_score), 0);
`else
    check("final_608", 32'(final_score), 151);
`endif

    // run low mid-MOVE freezes position and step counter
    do_reset();
    btn = 4'b0001;
    run = 1'b1;
    tick(3);
    check("pause_pre", 32'(pos_x), 1);
    run = 1'b0;
    tick(10);
    check("pause_hold", 32'(pos_x), 1);
    run = 1'b1;
    tick(1);
    check("pause_resume1", 32'(pos_x), 1);
    tick(1);
    check("pause_resume2", 32'(pos_x), 2);

    // Reset right before the DECIDE that would score cell 1
    rst = 1'b1;
    tick(1);
    check_reset_values("midrst");
    rst = 1'b0;
    btn = 4'd0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
